// File: rtl/monitor_contador_pkg.sv
// Shared definitions for the counter monitor: switch mode codes, FSM states
// and the active-low 7-segment glyphs (bit order g,f,e,d,c,b,a).
package monitor_contador_pkg;

  localparam logic [1:0] SOBE  = 2'b00;
  localparam logic [1:0] DESCE = 2'b01;
  localparam logic [1:0] LIVRE = 2'b10;
  localparam logic [1:0] PARA  = 2'b11;

  typedef enum logic [1:0] {
    SINC     = 2'd0,
    VERIFICA = 2'd1,
    FALHA    = 2'd2
  } estado_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_E = 7'b0000110;

endpackage

// File: rtl/monitor_contador_decod_7seg.sv
// Combinational 3-bit to 7-segment decoder with an "E" override; polarity
// selectable so other display blocks can reuse it.
module decod_7seg
  import monitor_contador_pkg::*;
#(
  parameter bit ATIVO_BAIXO = 1'b1
) (
  input  logic [2:0] valor,
  input  logic       mostra_e,
  output logic [6:0] segmentos
);

  logic [6:0] padrao;

  always_comb begin
    padrao = SEG_0;
    if (mostra_e) begin
      padrao = SEG_E;
    end else begin
      case (valor)
        3'd0:    padrao = SEG_0;
        3'd1:    padrao = SEG_1;
        3'd2:    padrao = SEG_2;
        3'd3:    padrao = SEG_3;
        3'd4:    padrao = SEG_4;
        3'd5:    padrao = SEG_5;
        3'd6:    padrao = SEG_6;
        default: padrao = SEG_7;
      endcase
    end
  end

  // Glyph table is stored active-low; invert for common-cathode boards.
  assign segmentos = ATIVO_BAIXO ? padrao : ~padrao;

endmodule

// File: rtl/monitor_contador.sv
// Watches a 3-bit switch-controlled counter, checks each step against the
// mode selected by the switches, and shows the sampled value on a 7-seg digit.
module monitor_contador
  import monitor_contador_pkg::*;
#(
  parameter int unsigned ERR_LIMIT       = 3,
  parameter bit          SEG_ATIVO_BAIXO = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] chaves,
  input  logic [2:0] contador,
  output logic [6:0] segmentos,
  output logic       direcao,
  output logic       parado,
  output logic       erro,
  output logic [3:0] erros,
  output logic       falha
);

  localparam logic [3:0] LIMITE = 4'(ERR_LIMIT);

  estado_t    estado_q, estado_d;
  logic [2:0] amostra_q;
  logic [1:0] modo_ant_q;
  logic [6:0] seg_q, seg_d;
  logic       direcao_q, parado_q, erro_q, erro_d;
  logic [3:0] erros_q, erros_d;
  logic [2:0] esperado, valor_seg;
  logic       muda_modo, mostra_e;

  always_comb begin
    case (modo_ant_q)
      SOBE:    esperado = amostra_q + 3'd1;
      DESCE:   esperado = amostra_q - 3'd1;
      default: esperado = amostra_q;
    endcase
  end

  // A mode change flips the counter's value immediately, so that cycle can't
  // be judged; resynchronise first.
  assign muda_modo = (chaves != modo_ant_q) || (chaves == LIVRE);

  always_comb begin
    estado_d = estado_q;
    erro_d   = 1'b0;
    erros_d  = erros_q;
    case (estado_q)
      SINC: begin
        if (chaves != LIVRE) estado_d = VERIFICA;
      end
      VERIFICA: begin
        if (muda_modo) begin
          estado_d = SINC;
        end else if (contador != esperado) begin
          erro_d  = 1'b1;
          erros_d = (erros_q == 4'd15) ? 4'd15 : erros_q + 4'd1;
          if (erros_d >= LIMITE) estado_d = FALHA;
        end
      end
      FALHA:   estado_d = FALHA;
      default: estado_d = SINC;
    endcase
  end

  // Reset is folded into the decoder inputs so the display resets to "0"
  // in whichever polarity is configured.
  assign valor_seg = reset ? 3'd0 : amostra_q;
  assign mostra_e  = !reset && (estado_d == FALHA);

  decod_7seg #(
    .ATIVO_BAIXO(SEG_ATIVO_BAIXO)
  ) u_decod (
    .valor    (valor_seg),
    .mostra_e (mostra_e),
    .segmentos(seg_d)
  );

  always_ff @(posedge clock) begin
    seg_q <= seg_d;
    if (reset) begin
      estado_q   <= SINC;
      amostra_q  <= 3'd0;
      modo_ant_q <= SOBE;
      direcao_q  <= 1'b0;
      parado_q   <= 1'b0;
      erro_q     <= 1'b0;
      erros_q    <= 4'd0;
    end else begin
      estado_q   <= estado_d;
      amostra_q  <= contador;
      modo_ant_q <= chaves;
      direcao_q  <= (chaves == DESCE);
      parado_q   <= (chaves == PARA);
      erro_q     <= erro_d;
      erros_q    <= erros_d;
    end
  end

  assign segmentos = seg_q;
  assign direcao   = direcao_q;
  assign parado    = parado_q;
  assign erro      = erro_q;
  assign erros     = erros_q;
  assign falha     = (estado_q == FALHA);

endmodule

// File: tb/tb_monitor_contador.sv
// Randomised and directed bench for monitor_contador against a behavioural model.
module tb_monitor_contador;

  localparam int LIM = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] chaves = 2'b00;
  logic [2:0] contador = 3'd0;
  logic [6:0] segmentos;
  logic       direcao, parado, erro, falha;
  logic [3:0] erros;

  monitor_contador #(
    .ERR_LIMIT      (LIM),
    .SEG_ATIVO_BAIXO(1'b1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .chaves   (chaves),
    .contador (contador),
    .segmentos(segmentos),
    .direcao  (direcao),
    .parado   (parado),
    .erro     (erro),
    .erros    (erros),
    .falha    (falha)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] pat[9];
  localparam logic [6:0] GLYPH_E = 7'b0000110;

  // Model state: last sample, last mode, whether the next cycle is judged.
  int         m_am, m_modo, m_erros;
  bit         m_arm, m_falha, m_erro, m_dir, m_par;
  logic [6:0] m_seg;

  task automatic model(input bit r, input int ch, input int ct);
    int exp;
    if (r) begin
      m_arm = 0; m_falha = 0; m_erros = 0; m_erro = 0; m_dir = 0; m_par = 0;
      m_seg = pat[0]; m_am = 0; m_modo = 0;
      return;
    end
    m_erro = 0;
    if (!m_falha) begin
      if (!m_arm) m_arm = (ch != 2);
      else if (ch != m_modo || ch == 2) m_arm = 0;
      else begin
        exp = (m_modo == 0) ? (m_am + 1) % 8 : (m_modo == 1) ? (m_am + 7) % 8 : m_am;
        if (ct != exp) begin
          m_erro = 1;
          if (m_erros < 15) m_erros++;
          if (m_erros >= LIM) m_falha = 1;
        end
      end
    end
    m_seg = m_falha ? GLYPH_E : pat[m_am];
    m_dir = (ch == 1);
    m_par = (ch == 3);
    m_am  = ct;
    m_modo = ch;
  endtask

  task automatic step(input bit r, input int ch, input int ct);
    reset    = r;
    chaves   = ch[1:0];
    contador = ct[2:0];
    @(posedge clock);
    model(r, ch, ct);
    @(negedge clock);
    chk("seg",   segmentos, m_seg);
    chk("dir",   direcao,   m_dir);
    chk("par",   parado,    m_par);
    chk("erro",  erro,      m_erro);
    chk("erros", erros,     m_erros);
    chk("falha", falha,     m_falha);
  endtask

  initial begin
    int gch, gcnt, ct;
    bit r;
    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000110};

    step(1, 0, 0);
    step(1, 0, 0);
    chk("rst_seg", segmentos, 7'b1000000);
    chk("rst_erros", erros, 4'd0);

    // Up count with wrap.
    for (int i = 0; i < 10; i++) begin
      step(0, 0, i % 8);
      if (i == 7) chk("seg_six", segmentos, 7'b0000010);
      if (i == 9) chk("seg_wrap", segmentos, 7'b1000000);
      chk("up_noerr", erro, 1'b0);
    end
    chk("up_dir", direcao, 1'b0);

    // Down count with 0 -> 7 wrap.
    for (int i = 0; i < 9; i++) begin
      step(0, 1, (7 - i + 8) % 8);
      chk("dn_noerr", erro, 1'b0);
    end
    chk("dn_dir", direcao, 1'b1);
    chk("dn_erros", erros, 4'd0);

    // Mismatches up to the limit.
    step(0, 0, 2);
    step(0, 0, 3);
    step(0, 0, 5);
    chk("mm1_erro", erro, 1'b1);
    chk("mm1_erros", erros, 4'd1);
    step(0, 0, 5);
    step(0, 0, 1);
    chk("lim_falha", falha, 1'b1);
    chk("lim_seg", segmentos, GLYPH_E);
    step(0, 0, 7);
    step(0, 0, 4);
    chk("frozen_erros", erros, 4'd3);

    step(1, 0, 0);
    chk("clr_falha", falha, 1'b0);
    chk("clr_erros", erros, 4'd0);
    chk("clr_seg", segmentos, 7'b1000000);

    // Mode change with value inversion.
    for (int i = 0; i < 4; i++) step(0, 0, i);
    step(0, 1, 4);
    step(0, 1, 3);
    step(0, 1, 2);
    chk("inv_erros", erros, 4'd0);

    // Hold mode.
    for (int i = 0; i < 3; i++) step(0, 3, 5);
    chk("hold_par", parado, 1'b1);
    chk("hold_noerr", erro, 1'b0);
    step(0, 3, 6);
    chk("hold_erro", erro, 1'b1);
    chk("hold_erros", erros, 4'd1);

    // Free mode is never judged.
    step(1, 2, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 2, $urandom_range(0, 7));
      chk("livre_noerr", erro, 1'b0);
    end

    // Random sequences with occasional glitches, mode flips and resets.
    gch = 0;
    gcnt = 0;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) gch = $urandom_range(0, 3);
      case (gch)
        0: gcnt = (gcnt + 1) % 8;
        1: gcnt = (gcnt + 7) % 8;
        2: gcnt = $urandom_range(0, 7);
        default: gcnt = gcnt;
      endcase
      ct = gcnt;
      if ($urandom_range(0, 29) == 0) ct = $urandom_range(0, 7);
      step(r, gch, ct);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
